// File: rtl/glitch_pulse_gen.sv
// glitch_pulse_gen: armed, one-shot burst generator for the glitch driver.
// A trig in ARMED starts a burst of pulse_count pulses. Each pulse is
// pulse_width cycles active with pulse_gap idle cycles between pulses.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   arm, abort      - arm level and force-to-idle request
//   trig            - one-cycle start pulse from the delay stage
//   pulse_width/gap - per-pulse active and idle lengths (0 means 1)
//   pulse_count     - pulses per burst (0 means 1)
//   clr_overrun     - clears the sticky overrun flag
//   glitch_out      - registered glitch drive (polarity from ACTIVE_HIGH)
//   armed, busy     - state indicators, registered
//   done            - one-cycle pulse after the last active cycle
//   overrun         - sticky, set by trig while a burst is running
module glitch_pulse_gen #(
  parameter int unsigned WIDTH_BITS  = 32,
  parameter int unsigned COUNT_BITS  = 16,
  parameter bit          ACTIVE_HIGH = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trig,
  input  logic [WIDTH_BITS-1:0] pulse_width,
  input  logic [WIDTH_BITS-1:0] pulse_gap,
  input  logic [COUNT_BITS-1:0] pulse_count,
  input  logic                  clr_overrun,
  output logic                  glitch_out,
  output logic                  armed,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam logic ACT_LVL  = ACTIVE_HIGH;
  localparam logic IDLE_LVL = !ACTIVE_HIGH;

  typedef enum logic [1:0] {IDLE, ARMED, HIGH, GAP} state_t;

  state_t                state, state_nxt;
  logic [WIDTH_BITS-1:0] cnt, cnt_nxt;
  logic [WIDTH_BITS-1:0] width_lat, width_nxt;
  logic [WIDTH_BITS-1:0] gap_lat, gap_nxt;
  logic [COUNT_BITS-1:0] rem, rem_nxt;
  logic                  done_nxt, overrun_nxt;
  logic [WIDTH_BITS-1:0] w_eff, g_eff;
  logic [COUNT_BITS-1:0] n_eff;

  // Zero-to-one substitution on the configuration inputs.
  assign w_eff = (pulse_width == '0) ? WIDTH_BITS'(1) : pulse_width;
  assign g_eff = (pulse_gap   == '0) ? WIDTH_BITS'(1) : pulse_gap;
  assign n_eff = (pulse_count == '0) ? COUNT_BITS'(1) : pulse_count;

  // Next-state and next-output logic. Counters run down to zero, so the
  // terminal compare never needs W or G itself and W = 2^WIDTH_BITS-1 works.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    width_nxt   = width_lat;
    gap_nxt     = gap_lat;
    rem_nxt     = rem;
    done_nxt    = 1'b0;
    overrun_nxt = overrun;

    // Set beats clear when both land in the same cycle.
    if (clr_overrun) overrun_nxt = 1'b0;
    if (trig && (state == HIGH || state == GAP)) overrun_nxt = 1'b1;

    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (arm) state_nxt = ARMED;
        end
        ARMED: begin
          if (trig) begin
            state_nxt = HIGH;
            width_nxt = w_eff;
            gap_nxt   = g_eff;
            rem_nxt   = n_eff;
            cnt_nxt   = w_eff - WIDTH_BITS'(1);
          end else if (!arm) begin
            state_nxt = IDLE;
          end
        end
        HIGH: begin
          if (cnt == '0) begin
            if (rem > COUNT_BITS'(1)) begin
              state_nxt = GAP;
              cnt_nxt   = gap_lat - WIDTH_BITS'(1);
            end else begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end else begin
            cnt_nxt = cnt - WIDTH_BITS'(1);
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state_nxt = HIGH;
            cnt_nxt   = width_lat - WIDTH_BITS'(1);
            rem_nxt   = rem - COUNT_BITS'(1);
          end else begin
            cnt_nxt = cnt - WIDTH_BITS'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and registered outputs; outputs are decoded from the next state
  // so glitch_out goes active on the very edge that samples trig.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      width_lat  <= '0;
      gap_lat    <= '0;
      rem        <= '0;
      glitch_out <= IDLE_LVL;
      armed      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      width_lat  <= width_nxt;
      gap_lat    <= gap_nxt;
      rem        <= rem_nxt;
      glitch_out <= (state_nxt == HIGH) ? ACT_LVL : IDLE_LVL;
      armed      <= (state_nxt == ARMED);
      busy       <= (state_nxt == HIGH) || (state_nxt == GAP);
      done       <= done_nxt;
      overrun    <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Testbench for glitch_pulse_gen: directed scenarios plus random stimulus,
// every cycle compared against a waveform-queue reference model.
module tb_glitch_pulse_gen;

  logic        clk = 1'b0;
  logic        rst, arm, abort, trig, clr;
  logic [31:0] pw, pg;
  logic [15:0] pn;
  logic        glitch_out, armed, busy, done, overrun;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  glitch_pulse_gen dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig(trig),
    .pulse_width(pw), .pulse_gap(pg), .pulse_count(pn),
    .clr_overrun(clr),
    .glitch_out(glitch_out), .armed(armed), .busy(busy),
    .done(done), .overrun(overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a burst is the explicit list of per-cycle glitch levels.
  int m_mode;       // 0 idle, 1 armed, 2 burst
  bit m_q[$];
  bit m_ovr, m_done;

  function automatic int unsigned eff(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_step();
    int unsigned w, g, n;
    if (rst) begin
      m_mode = 0; m_q.delete(); m_ovr = 0; m_done = 0;
      return;
    end
    m_done = 0;
    if (clr) m_ovr = 0;
    if (trig && m_mode == 2) m_ovr = 1;
    if (abort) begin
      m_mode = 0; m_q.delete();
    end else if (m_mode == 0) begin
      if (arm) m_mode = 1;
    end else if (m_mode == 1) begin
      if (trig) begin
        w = eff(pw); g = eff(32'(pg)); n = eff(32'(pn));
        for (int p = 0; p < int'(n); p++) begin
          if (p > 0) for (int i = 0; i < int'(g); i++) m_q.push_back(1'b0);
          for (int i = 0; i < int'(w); i++) m_q.push_back(1'b1);
        end
        m_mode = 2;
      end else if (!arm) begin
        m_mode = 0;
      end
    end else begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_mode = 0; m_done = 1;
      end
    end
  endtask

  // One clock: DUT and model see the same inputs, outputs checked #1 later.
  task automatic cyc();
    bit eg;
    @(posedge clk);
    model_step();
    #1;
    eg = (m_mode == 2) ? m_q[0] : 1'b0;
    check("glitch_out", 32'(glitch_out), 32'(eg));
    check("armed",      32'(armed),      32'(m_mode == 1));
    check("busy",       32'(busy),       32'(m_mode == 2));
    check("done",       32'(done),       32'(m_done));
    check("overrun",    32'(overrun),    32'(m_ovr));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Arm for one cycle, then fire trig for one cycle with the given config.
  task automatic start(input logic [31:0] w, input logic [31:0] g, input logic [15:0] n);
    arm = 1'b1; pw = w; pg = g; pn = n;
    cyc();
    trig = 1'b1;
    cyc();
    trig = 1'b0;
  endtask

  logic [12:0] pat;
  int          cnt;
  bit          early;

  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; trig = 1'b0; clr = 1'b0;
    pw = '0; pg = '0; pn = '0;

    // Reset values, then arm held high after release.
    run(3);
    check("rst_glitch", 32'(glitch_out), 32'(0));
    check("rst_overrun", 32'(overrun), 32'(0));
    rst = 1'b0; arm = 1'b1;
    cyc();
    check("armed_after_rst", 32'(armed), 32'(1));

    // Single pulse W=5, N=1.
    start(32'd5, 32'd3, 16'd1);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cnt += int'(glitch_out);
      cyc();
    end
    check("w5_high_cycles", 32'(cnt), 32'(5));
    check("w5_done", 32'(done), 32'(1));
    check("w5_busy", 32'(busy), 32'(0));
    check("w5_glitch_idle", 32'(glitch_out), 32'(0));
    run(2);

    // Burst W=3 G=2 N=3 with config scrambled mid-burst.
    start(32'd3, 32'd2, 16'd3);
    pat = '0; early = 1'b0;
    for (int i = 0; i < 13; i++) begin
      pat = {pat[11:0], glitch_out};
      early |= done;
      pw = $urandom_range(0, 9); pg = $urandom_range(0, 9); pn = 16'($urandom_range(0, 9));
      cyc();
    end
    check("burst_pattern", 32'(pat), 32'(13'b1110011100111));
    check("burst_no_early_done", 32'(early), 32'(0));
    check("burst_done", 32'(done), 32'(1));
    run(2);

    // Zero substitution: single 1-cycle pulse, then N=2 gives 1 0 1.
    start(32'd0, 32'd0, 16'd0);
    check("zero_high", 32'(glitch_out), 32'(1));
    cyc();
    check("zero_done", 32'(done), 32'(1));
    run(2);
    start(32'd0, 32'd0, 16'd2);
    pat = '0;
    for (int i = 0; i < 3; i++) begin
      pat = {pat[11:0], glitch_out};
      cyc();
    end
    check("zero_n2_pattern", 32'(pat[2:0]), 32'(3'b101));
    check("zero_n2_done", 32'(done), 32'(1));
    run(2);

    // Trig in IDLE is ignored.
    arm = 1'b0;
    run(2);
    trig = 1'b1;
    cyc();
    trig = 1'b0;
    run(3);
    check("idle_trig_overrun", 32'(overrun), 32'(0));

    // Trig during HIGH sets overrun without disturbing the burst.
    start(32'd4, 32'd1, 16'd1);
    cyc();
    trig = 1'b1;
    cyc();
    trig = 1'b0;
    check("busy_trig_overrun", 32'(overrun), 32'(1));
    run(4);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    check("clr_overrun", 32'(overrun), 32'(0));

    // Same-cycle set and clear keeps overrun set.
    start(32'd4, 32'd1, 16'd1);
    trig = 1'b1; clr = 1'b1;
    cyc();
    trig = 1'b0; clr = 1'b0;
    check("set_beats_clr", 32'(overrun), 32'(1));
    run(5);

    // Abort mid-burst: W=10, abort in the fourth active cycle.
    start(32'd10, 32'd1, 16'd1);
    run(3);
    abort = 1'b1; arm = 1'b0;
    cyc();
    abort = 1'b0;
    check("abort_glitch", 32'(glitch_out), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    run(12);

    // Reset mid-burst also clears overrun.
    start(32'd10, 32'd1, 16'd1);
    trig = 1'b1;
    run(3);
    trig = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0; arm = 1'b0;
    check("rst_mid_glitch", 32'(glitch_out), 32'(0));
    check("rst_mid_overrun", 32'(overrun), 32'(0));
    run(12);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      arm   = ($urandom_range(0, 9) != 0);
      trig  = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 79) == 0);
      clr   = ($urandom_range(0, 19) == 0);
      pw    = $urandom_range(0, 6);
      pg    = $urandom_range(0, 4);
      pn    = 16'($urandom_range(0, 4));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/glitch_pulse_gen.md
Name: glitch_pulse_gen

Overview:
- Downstream of the trigger-delay stage: consumes its one-cycle `ready` pulse as `trig` and drives the glitch output.
- Emits a programmable burst of `pulse_count` pulses. Each pulse is `pulse_width` cycles active, with `pulse_gap` idle cycles between pulses.
- One-shot per arm: must be re-armed after each burst. Sits between the delay stage and the glitch MOSFET/clock-mux driver.

Parameters:
- WIDTH_BITS, 32: width of the pulse_width and pulse_gap fields and their counters.
- COUNT_BITS, 16: width of the pulse_count field and its counter.
- ACTIVE_HIGH, 1: 1 means glitch_out idles 0 and pulses 1; 0 inverts both levels.

Ports:
- clk, in, 1: sole clock.
- rst, in, 1: synchronous, active-high reset.
- arm, in, 1: level. High in IDLE moves to ARMED; low in ARMED returns to IDLE.
- abort, in, 1: forces IDLE from any state.
- trig, in, 1: one-cycle start pulse from the delay stage.
- pulse_width, in, WIDTH_BITS: active cycles per pulse; 0 is treated as 1.
- pulse_gap, in, WIDTH_BITS: idle cycles between pulses; 0 is treated as 1.
- pulse_count, in, COUNT_BITS: pulses per burst; 0 is treated as 1.
- clr_overrun, in, 1: clears the overrun flag.
- glitch_out, out, 1: registered glitch drive.
- armed, out, 1: high while in ARMED.
- busy, out, 1: high while in HIGH or GAP.
- done, out, 1: one-cycle pulse after the last pulse of a burst.
- overrun, out, 1: sticky; set by trig while busy.

Behaviour:
- Clocking and reset: one clock, `clk`. Reset is synchronous and active-high on `rst`. With `rst` high at an edge:
  - state=IDLE; glitch_out=idle level; armed=busy=done=overrun=0; counters cleared.
  - Holds mid-burst: glitch_out returns to idle level at that same edge.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, ARMED, HIGH, GAP.
- IDLE:
  - arm=1 -> ARMED.
  - trig is ignored and does not set overrun.
- ARMED:
  - trig=1 -> HIGH. At the same edge, latch pulse_width, pulse_gap and pulse_count with the 0->1 substitution applied.
  - trig=1 wins over arm=0 in the same cycle.
  - arm=0 with trig=0 -> IDLE.
- Latency: trig sampled at edge t puts glitch_out at the active level from edge t (visible in cycle t+1). Fixed one-cycle latency, no jitter.
- HIGH:
  - glitch_out active for exactly W latched cycles.
  - On the last cycle: if pulses remaining > 1 -> GAP; else -> IDLE with done=1 for one cycle and glitch_out idle.
- GAP:
  - glitch_out idle for exactly G latched cycles, then -> HIGH and decrement pulses remaining.
- Configuration inputs may change during a burst; only latched values are used.
- Counters run down from W-1/G-1 and compare to 0. Use full-width compares only; no wrap. Maximum W = 2^WIDTH_BITS-1 must work.
- trig while HIGH or GAP:
  - Ignored for sequencing; sets overrun.
  - If clr_overrun and a set event fall on the same cycle, set wins.
- abort:
  - Takes priority over everything except rst.
  - At the next edge: state=IDLE, glitch_out idle, done not asserted.
- After done, the block is in IDLE. A new burst requires arm.
- Burst duration from trig to done: N*W + (N-1)*G cycles. done is asserted in the cycle immediately after the last active cycle.

Test Plan:
- Reset values: assert rst 3 cycles -> glitch_out=0, armed=busy=done=overrun=0. Hold arm=1 -> armed=1 one cycle after rst drops.
- Single pulse: arm, trig with W=5, N=1 -> glitch_out high exactly cycles t+1..t+5, done=1 at t+6, busy=0 at t+6.
- Burst: W=3, G=2, N=3 -> glitch_out pattern 111 00 111 00 111, then done. Total 13 active-window cycles. Changing inputs mid-burst has no effect.
- Zero substitution: W=0, G=0, N=0 -> one pulse of 1 cycle, then done. Separately, N=2 with W=0, G=0 -> pattern 1 0 1.
- Overrun and ignore:
  - trig in IDLE -> no pulse, overrun=0.
  - trig during HIGH -> overrun=1, burst unchanged.
  - clr_overrun -> overrun=0 next cycle.
  - Same-cycle set and clear -> overrun stays 1.
- Abort and reset mid-burst: W=10, abort at cycle 4 -> glitch_out=0 next cycle, no done, state IDLE. Repeat with rst instead -> same, and overrun cleared.
